fsk_symbol_sequencer: RTL and testbench

Upstream control stage for the 9-bit preloadable frequency divider in the digital modulation path. It accepts a parallel data word through a valid/ready handshake and serializes it MSB-first. For each bit it drives the divider's preload value (mark or space count) and a one-cycle `init` pulse, then holds that symbol for a programmable number of clock cycles. The divider's toggling output is the binary-FSK carrier.

---
 rtl/fsk_symbol_sequencer.sv | 104 ++++++++++
 tb/tb_fsk_symbol_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_symbol_sequencer.sv
// Binary-FSK symbol sequencer: serializes a data word MSB-first and drives a
// preloadable divider with a mark/space count plus a one-cycle init strobe per bit.
module fsk_symbol_sequencer #(
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [8:0]          cnt_mark,
  input  logic [8:0]          cnt_space,
  output logic [8:0]          cnt_ext,
  output logic                init,
  output logic                tx_bit,
  output logic                busy,
  output logic                done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [0:0]          state;
  logic [DATA_W-1:0]   shift_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] period_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic                bit_end;
  logic                last_bit;
  logic                head_bit;
  logic                next_bit;

  assign data_ready = (state == IDLE);
  assign bit_end    = (period_cnt == period_reg);
  assign last_bit   = (bit_idx == IDX_W'(DATA_W - 1));
  assign head_bit   = data_in[DATA_W-1];
  // shift_reg already has the first bit removed, so its MSB is the upcoming bit
  assign next_bit   = shift_reg[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      period_reg <= '0;
      period_cnt <= '0;
      bit_idx    <= '0;
      cnt_ext    <= '0;
      init       <= 1'b1;
      tx_bit     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          init    <= 1'b1;
          cnt_ext <= cnt_space;
          tx_bit  <= 1'b0;
          busy    <= 1'b0;
          if (data_valid) begin
            // Handshake edge also launches bit 0 so its init lands in the next cycle
            state      <= SEND;
            busy       <= 1'b1;
            shift_reg  <= data_in << 1;
            period_reg <= (bit_period == '0) ? PERIOD_W'(1) : bit_period;
            period_cnt <= PERIOD_W'(1);
            bit_idx    <= '0;
            tx_bit     <= head_bit;
            cnt_ext    <= head_bit ? cnt_mark : cnt_space;
          end
        end
        SEND: begin
          if (bit_end) begin
            init <= 1'b1;
            if (last_bit) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              cnt_ext    <= cnt_space;
              tx_bit     <= 1'b0;
              shift_reg  <= '0;
              period_cnt <= '0;
              bit_idx    <= '0;
            end else begin
              bit_idx    <= bit_idx + 1'b1;
              period_cnt <= PERIOD_W'(1);
              shift_reg  <= shift_reg << 1;
              tx_bit     <= next_bit;
              cnt_ext    <= next_bit ? cnt_mark : cnt_space;
            end
          end else begin
            init       <= 1'b0;
            period_cnt <= period_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// Scoreboard bench for fsk_symbol_sequencer: stimulus pushes expected init/done
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_fsk_symbol_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] bit_period;
  logic [8:0]  cnt_mark;
  logic [8:0]  cnt_space;
  logic [8:0]  cnt_ext;
  logic        init;
  logic        tx_bit;
  logic        busy;
  logic        done;

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [8:0] cnt;
    logic       tx;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] last_cnt = '0;
  logic       last_tx = 1'b0;

  fsk_symbol_sequencer #(.DATA_W(8), .PERIOD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .bit_period (bit_period),
    .cnt_mark   (cnt_mark),
    .cnt_space  (cnt_space),
    .cnt_ext    (cnt_ext),
    .init       (init),
    .tx_bit     (tx_bit),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " init"}, int'(init), 1);
    checkOutput({tag, " cnt_ext"}, int'(cnt_ext), 0);
    checkOutput({tag, " tx_bit"}, int'(tx_bit), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " data_ready"}, int'(data_ready), 1);
  endtask

  // Expected init events for the first nbits bits, with mark switching to m1 from bit chg on
  task automatic pushFrame(input int e0, input int p, input logic [7:0] d, input int nbits,
                           input bit with_done, input logic [8:0] m0, input logic [8:0] m1,
                           input int chg, input logic [8:0] sp);
    exp_t e;
    for (int k = 0; k < nbits; k++) begin
      e.is_done = 1'b0;
      e.cyc     = e0 + k * p;
      e.tx      = d[7-k];
      e.cnt     = d[7-k] ? ((k >= chg) ? m1 : m0) : sp;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.cyc     = e0 + 8 * p;
      e.tx      = 1'b0;
      e.cnt     = sp;
      exp_q.push_back(e);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Waits (bounded) for the idle handshake window, then presents one word
  task automatic applyStimulus(input logic [7:0] d, input logic [15:0] p, output int e0);
    int tries = 0;
    @(negedge clk);
    while (!data_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!data_ready) checkOutput("handshake timeout data_ready", int'(data_ready), 1);
    data_in    = d;
    bit_period = p;
    data_valid = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = ~d;
    bit_period = p + 16'd3;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (busy && init) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected init event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("init kind", int'(e.is_done), 0);
          checkOutput("init cycle", cyc, e.cyc);
          checkOutput("init cnt_ext", int'(cnt_ext), int'(e.cnt));
          checkOutput("init tx_bit", int'(tx_bit), int'(e.tx));
          last_cnt = e.cnt;
          last_tx  = e.tx;
        end
      end else if (busy) begin
        checkOutput("hold cnt_ext", int'(cnt_ext), int'(last_cnt));
        checkOutput("hold tx_bit", int'(tx_bit), int'(last_tx));
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done kind", int'(e.is_done), 1);
          checkOutput("done cycle", cyc, e.cyc);
          checkOutput("done init", int'(init), 1);
          checkOutput("done cnt_ext", int'(cnt_ext), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e0;
    int e1;
    rst        = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    bit_period = 16'd4;
    cnt_mark   = 9'd500;
    cnt_space  = 9'd480;

    repeat (3) @(negedge clk);
    checkResetOutputs("power-on reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle cnt_ext after release", int'(cnt_ext), 480);
    checkOutput("idle data_ready", int'(data_ready), 1);

    // Asynchronous assertion in the middle of the high phase
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cnt_ext first edge after release", int'(cnt_ext), 480);

    $display("[TB] single frame A5, P=4");
    applyStimulus(8'hA5, 16'd4, e0);
    pushFrame(e0, 4, 8'hA5, 8, 1'b1, 9'd500, 9'd500, 8, 9'd480);
    waitUntil(e0 + 34);

    $display("[TB] zero period FF");
    applyStimulus(8'hFF, 16'd0, e0);
    pushFrame(e0, 1, 8'hFF, 8, 1'b1, 9'd500, 9'd500, 8, 9'd480);
    waitUntil(e0 + 10);

    $display("[TB] back-to-back 0F then F0, P=2");
    @(negedge clk);
    data_in    = 8'h0F;
    bit_period = 16'd2;
    data_valid = 1'b1;
    e0 = cyc + 1;
    pushFrame(e0, 2, 8'h0F, 8, 1'b1, 9'd500, 9'd500, 8, 9'd480);
    waitUntil(e0 + 1);
    data_in    = 8'h33;
    bit_period = 16'd7;
    waitUntil(e0 + 16);
    data_in    = 8'hF0;
    bit_period = 16'd2;
    e1 = e0 + 17;
    pushFrame(e1, 2, 8'hF0, 8, 1'b1, 9'd500, 9'd500, 8, 9'd480);
    waitUntil(e1);
    data_valid = 1'b0;
    data_in    = 8'hAA;
    bit_period = 16'd9;
    waitUntil(e1 + 18);

    $display("[TB] reset during bit 3");
    applyStimulus(8'h96, 16'd4, e0);
    pushFrame(e0, 4, 8'h96, 4, 1'b0, 9'd500, 9'd500, 8, 9'd480);
    waitUntil(e0 + 13);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("mid-frame reset");
    checkOutput("bits emitted before abort", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h5A, 16'd3, e0);
    pushFrame(e0, 3, 8'h5A, 8, 1'b1, 9'd500, 9'd500, 8, 9'd480);
    waitUntil(e0 + 26);

    $display("[TB] live preload change");
    applyStimulus(8'hC3, 16'd4, e0);
    pushFrame(e0, 4, 8'hC3, 8, 1'b1, 9'd500, 9'd510, 1, 9'd480);
    waitUntil(e0 + 2);
    cnt_mark = 9'd510;
    waitUntil(e0 + 34);
    cnt_mark = 9'd500;

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
